// File: rtl/accumulator_control.sv
// Fetch/decode/execute controller for the 8-bit accumulator core.
// Holds acc and Z/C flags and drives the register file write port.
module accumulator_control #(
    parameter int PC_W     = 4,
    parameter int START_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    output logic [1:0]      register_address,
    output logic            we,
    output logic [7:0]      accumulator_input,
    input  logic [7:0]      register_value,
    output logic [7:0]      acc_out,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDR = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_q, instr_d;
    logic [7:0]      acc_q, acc_d;
    logic            z_q, z_d;
    logic            c_q, c_d;

    logic [3:0]      op;
    logic [8:0]      sum;
    logic [8:0]      diff;

    assign op   = instr_q[7:4];
    assign sum  = {1'b0, acc_q} + {1'b0, register_value};
    assign diff = {1'b0, acc_q} - {1'b0, register_value};

    // State, pc, instruction and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(START_PC);
            instr_q <= 8'h00;
            acc_q   <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Next-state sequencing and instruction execution
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = prog_data;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (op)
                    OP_LDR: begin
                        acc_d = register_value;
                        z_d   = (register_value == 8'h00);
                    end
                    OP_ADD: begin
                        acc_d = sum[7:0];
                        c_d   = sum[8];
                        z_d   = (sum[7:0] == 8'h00);
                    end
                    OP_SUB: begin
                        acc_d = diff[7:0];
                        c_d   = (acc_q < register_value);
                        z_d   = (diff[7:0] == 8'h00);
                    end
                    OP_AND: begin
                        acc_d = acc_q & register_value;
                        c_d   = 1'b0;
                        z_d   = ((acc_q & register_value) == 8'h00);
                    end
                    OP_OR: begin
                        acc_d = acc_q | register_value;
                        c_d   = 1'b0;
                        z_d   = ((acc_q | register_value) == 8'h00);
                    end
                    OP_XOR: begin
                        acc_d = acc_q ^ register_value;
                        c_d   = 1'b0;
                        z_d   = ((acc_q ^ register_value) == 8'h00);
                    end
                    OP_LDI: begin
                        acc_d = {4'b0000, instr_q[3:0]};
                        z_d   = (instr_q[3:0] == 4'h0);
                    end
                    OP_JZ: begin
                        if (z_q) pc_d = PC_W'(instr_q[3:0]);
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        // NOP, STR (write handled on the output side)
                        // and unused opcodes leave the datapath alone
                    end
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register file port and status outputs
    always_comb begin
        register_address = 2'b00;
        we               = 1'b0;
        if (state_q == S_EXEC) begin
            register_address = instr_q[1:0];
            we               = (op == OP_STR) && !rst;
        end
    end

    assign prog_addr         = pc_q;
    assign accumulator_input = acc_q;
    assign acc_out           = acc_q;
    assign zero_flag         = z_q;
    assign carry_flag        = c_q;
    assign halted            = (state_q == S_HALT);

endmodule

// File: tb/tb_accumulator_control.sv
// Directed bench for accumulator_control with a ROM and
// register file modelled alongside the DUT.
module tb_accumulator_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] prog_addr;
    logic [7:0] prog_data = 8'h00;
    logic [1:0] register_address;
    logic       we;
    logic [7:0] accumulator_input;
    logic [7:0] register_value;
    logic [7:0] acc_out;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [16];
    logic [7:0] regs [4];
    logic [7:0] regs_init [4];
    logic       load = 1'b0;
    int         wcnt = 0;
    logic [1:0] waddr = 2'b00;
    logic [7:0] wdata = 8'h00;

    accumulator_control #(.PC_W(4), .START_PC(0)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .prog_addr         (prog_addr),
        .prog_data         (prog_data),
        .register_address  (register_address),
        .we                (we),
        .accumulator_input (accumulator_input),
        .register_value    (register_value),
        .acc_out           (acc_out),
        .zero_flag         (zero_flag),
        .carry_flag        (carry_flag),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    // synchronous program ROM
    always @(posedge clk) prog_data <= rom[prog_addr];

    // register file with combinational read
    assign register_value = regs[register_address];

    always @(posedge clk) begin
        if (load) begin
            regs <= regs_init;
            wcnt <= 0;
        end else if (we) begin
            regs[register_address] <= accumulator_input;
            wcnt  <= wcnt + 1;
            waddr <= register_address;
            wdata <= accumulator_input;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int i = 0; i < 4; i++) regs_init[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b0;
    endtask

    // start sampled on the next edge (E0)
    task automatic go();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200 && !halted; i++) @(posedge clk);
        #1;
        chk(tag, 16'(halted), 16'd1);
    endtask

    initial begin
        // reset state
        clear_all();
        do_reset();
        chk("rst_pc", 16'(prog_addr), 16'h0);
        chk("rst_we", 16'(we), 16'h0);
        chk("rst_addr", 16'(register_address), 16'h0);
        chk("rst_acc", 16'(acc_out), 16'h0);
        chk("rst_zc", 16'({zero_flag, carry_flag}), 16'h0);
        chk("rst_halt", 16'(halted), 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", 16'(prog_addr), 16'h0);

        // 1: LDI 3; STR r3; ADD r3; HLT
        clear_all();
        rom[0] = 8'h83; rom[1] = 8'h23; rom[2] = 8'h33; rom[3] = 8'hF0;
        do_reset();
        go();
        repeat (11) @(posedge clk);
        #1;
        chk("t1_not_halt_e11", 16'(halted), 16'h0);
        @(posedge clk);
        #1;
        chk("t1_halt_e12", 16'(halted), 16'h1);
        chk("t1_wcnt", 16'(wcnt), 16'd1);
        chk("t1_waddr", 16'(waddr), 16'h3);
        chk("t1_wdata", 16'(wdata), 16'h3);
        chk("t1_reg3", 16'(regs[3]), 16'h3);
        chk("t1_acc", 16'(acc_out), 16'h6);
        chk("t1_zc", 16'({zero_flag, carry_flag}), 16'h0);

        // 2: LDR r0 (0xFF); ADD r1 (0x01)
        clear_all();
        regs_init[0] = 8'hFF; regs_init[1] = 8'h01;
        rom[0] = 8'h10; rom[1] = 8'h31; rom[2] = 8'hF0;
        do_reset();
        go();
        wait_halt("t2_halt");
        chk("t2_acc", 16'(acc_out), 16'h00);
        chk("t2_z", 16'(zero_flag), 16'h1);
        chk("t2_c", 16'(carry_flag), 16'h1);

        // 3a: LDI 2; SUB r2 (0x03)
        clear_all();
        regs_init[2] = 8'h03;
        rom[0] = 8'h82; rom[1] = 8'h42; rom[2] = 8'hF0;
        do_reset();
        go();
        wait_halt("t3a_halt");
        chk("t3a_acc", 16'(acc_out), 16'hFF);
        chk("t3a_c", 16'(carry_flag), 16'h1);
        chk("t3a_z", 16'(zero_flag), 16'h0);

        // 3b: ...then AND r3 (0x00)
        rom[2] = 8'h53; rom[3] = 8'hF0;
        do_reset();
        go();
        wait_halt("t3b_halt");
        chk("t3b_acc", 16'(acc_out), 16'h00);
        chk("t3b_z", 16'(zero_flag), 16'h1);
        chk("t3b_c", 16'(carry_flag), 16'h0);

        // 3c: LDI 5; OR r1 (0x0A) -> 0x0F; XOR r2 (0x3C) -> 0x33
        clear_all();
        regs_init[1] = 8'h0A; regs_init[2] = 8'h3C;
        rom[0] = 8'h85; rom[1] = 8'h61; rom[2] = 8'h72; rom[3] = 8'hF0;
        do_reset();
        go();
        wait_halt("t3c_halt");
        chk("t3c_acc", 16'(acc_out), 16'h33);
        chk("t3c_zc", 16'({zero_flag, carry_flag}), 16'h0);

        // 4a: LDI 0; JZ 0xA -> taken
        clear_all();
        rom[0] = 8'h80; rom[1] = 8'h9A; rom[2] = 8'hF0;
        rom[10] = 8'h87; rom[11] = 8'hF0;
        do_reset();
        go();
        repeat (6) @(posedge clk);
        #1;
        chk("t4a_jump_pc", 16'(prog_addr), 16'hA);
        wait_halt("t4a_halt");
        chk("t4a_acc", 16'(acc_out), 16'h07);

        // 4b: LDI 1; JZ 0xA -> not taken
        rom[0] = 8'h81;
        do_reset();
        go();
        repeat (6) @(posedge clk);
        #1;
        chk("t4b_fall_pc", 16'(prog_addr), 16'h2);
        wait_halt("t4b_halt");
        chk("t4b_acc", 16'(acc_out), 16'h01);

        // 5: LDI 5 then 15 NOPs, pc wraps to 0
        clear_all();
        rom[0] = 8'h85;
        do_reset();
        go();
        repeat (45) @(posedge clk);
        #1;
        chk("t5_pc15", 16'(prog_addr), 16'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_wrap", 16'(prog_addr), 16'h0);
        chk("t5_acc", 16'(acc_out), 16'h05);
        chk("t5_zc", 16'({zero_flag, carry_flag}), 16'h0);
        chk("t5_halt", 16'(halted), 16'h0);

        // 6a: rst during EXEC of STR r1
        clear_all();
        rom[0] = 8'h85; rom[1] = 8'h21; rom[2] = 8'hF0;
        do_reset();
        go();
        repeat (5) @(posedge clk);
        #1;
        chk("t6_we_exec", 16'(we), 16'h1);
        chk("t6_addr_exec", 16'(register_address), 16'h1);
        chk("t6_data_exec", 16'(accumulator_input), 16'h05);
        rst = 1'b1;
        #1;
        chk("t6_we_gated", 16'(we), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_reg1", 16'(regs[1]), 16'h00);
        chk("t6_wcnt", 16'(wcnt), 16'd0);
        chk("t6_acc", 16'(acc_out), 16'h00);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle_pc", 16'(prog_addr), 16'h0);
        chk("t6_idle_halt", 16'(halted), 16'h0);

        // 6b: start while halted is ignored
        clear_all();
        rom[0] = 8'hF0;
        do_reset();
        go();
        wait_halt("t6b_halt");
        go();
        repeat (6) @(posedge clk);
        #1;
        chk("t6b_still_halt", 16'(halted), 16'h1);
        chk("t6b_pc", 16'(prog_addr), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
